uart_byte_phy: RTL

- 8N1 UART byte transceiver at the bottom of the host link.
- Deserialises `uart_rx` into single-cycle byte strobes and serialises one byte per `tx_data_en` strobe onto `uart_tx`.
- Directly feeds the command/data controller above it (`rx_data`/`rx_data_en`) and consumes its transmit bytes (`tx_data`/`tx_data_en`).
- Provides the `tx_start`/`tx_busy` handshake the controller uses for back-to-back byte pacing.

---
 rtl/uart_byte_phy.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_byte_phy.sv
// 8N1 UART byte transceiver: independent RX deserialiser and TX serialiser.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each RX sample point.
module uart_byte_phy #(
  parameter int CLK_FREQ_HZ  = 100000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic [7:0] tx_data,
  input  logic       tx_data_en,
  output logic       tx_start,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_data_en
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_TICKS  = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TICKS = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] ONE_TICK   = CW'(1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  logic            s1_r, s2_r, s3_r;
  logic            start_edge_s;
  rx_state_t       rx_state_r;
  logic [CW-1:0]   rx_cnt_r;
  logic [2:0]      rx_idx_r;
  logic [7:0]      rx_shreg_r;
  logic [7:0]      rx_data_r;
  logic            rx_data_en_r;
  logic            rx_expiry_s;
  logic            sample_valid_s;
  logic            sample_bit_s;

  tx_state_t       tx_state_r;
  logic [CW-1:0]   tx_cnt_r;
  logic [2:0]      tx_idx_r;
  logic [7:0]      tx_shreg_r;
  logic            uart_tx_r;
  logic            tx_start_r;
  logic            tx_busy_r;

  // Two-flop synchroniser plus history flop for start-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
      s3_r <= 1'b1;
    end else begin
      s1_r <= uart_rx;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Start edge and bit-period expiry decode
  always_comb begin
    start_edge_s = s3_r & ~s2_r;
    if (rx_state_r != R_IDLE) begin
      rx_expiry_s = (rx_cnt_r == ONE_TICK);
    end else begin
      rx_expiry_s = 1'b0;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic maj_pend_r, maj_a_r, maj_b_r;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Capture the expiry-1 and expiry samples; vote one clock later with expiry+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maj_pend_r <= 1'b0;
      maj_a_r    <= 1'b1;
      maj_b_r    <= 1'b1;
    end else if (rx_expiry_s) begin
      maj_pend_r <= 1'b1;
      maj_a_r    <= s3_r;
      maj_b_r    <= s2_r;
    end else begin
      maj_pend_r <= 1'b0;
    end
  end

  // Voted sample presented to the RX FSM
  always_comb begin
    sample_valid_s = maj_pend_r;
    sample_bit_s   = maj3(maj_a_r, maj_b_r, s2_r);
  end
`else
  // Single sample of the synchronised line at expiry
  always_comb begin
    sample_valid_s = rx_expiry_s;
    sample_bit_s   = s2_r;
  end
`endif

  // RX FSM: counter keeps free-running bit periods, transitions follow the sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r   <= R_IDLE;
      rx_cnt_r     <= '0;
      rx_idx_r     <= 3'd0;
      rx_shreg_r   <= 8'h00;
      rx_data_r    <= 8'h00;
      rx_data_en_r <= 1'b0;
    end else begin
      rx_data_en_r <= 1'b0;
      if (rx_state_r != R_IDLE) begin
        rx_cnt_r <= rx_expiry_s ? BIT_TICKS : (rx_cnt_r - ONE_TICK);
      end
      case (rx_state_r)
        R_IDLE: begin
          if (start_edge_s) begin
            rx_cnt_r   <= HALF_TICKS;
            rx_state_r <= R_START;
          end
        end
        R_START: begin
          if (sample_valid_s) begin
            if (!sample_bit_s) begin
              rx_idx_r   <= 3'd0;
              rx_state_r <= R_DATA;
            end else begin
              rx_state_r <= R_IDLE;
            end
          end
        end
        R_DATA: begin
          if (sample_valid_s) begin
            rx_shreg_r <= {sample_bit_s, rx_shreg_r[7:1]};
            if (rx_idx_r == 3'd7) begin
              rx_state_r <= R_STOP;
            end else begin
              rx_idx_r <= rx_idx_r + 3'd1;
            end
          end
        end
        R_STOP: begin
          if (sample_valid_s) begin
            if (sample_bit_s) begin
              rx_data_r    <= rx_shreg_r;
              rx_data_en_r <= 1'b1;
            end
            rx_state_r <= R_IDLE;
          end
        end
        default: rx_state_r <= R_IDLE;
      endcase
    end
  end

  // TX FSM: strobes are only looked at in T_IDLE, so overruns are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r <= T_IDLE;
      tx_cnt_r   <= '0;
      tx_idx_r   <= 3'd0;
      tx_shreg_r <= 8'h00;
      uart_tx_r  <= 1'b1;
      tx_start_r <= 1'b0;
      tx_busy_r  <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      case (tx_state_r)
        T_IDLE: begin
          if (tx_data_en) begin
            tx_shreg_r <= tx_data;
            tx_start_r <= 1'b1;
            tx_busy_r  <= 1'b1;
            uart_tx_r  <= 1'b0;
            tx_cnt_r   <= BIT_TICKS;
            tx_state_r <= T_START;
          end
        end
        T_START: begin
          if (tx_cnt_r == ONE_TICK) begin
            uart_tx_r  <= tx_shreg_r[0];
            tx_cnt_r   <= BIT_TICKS;
            tx_idx_r   <= 3'd0;
            tx_state_r <= T_DATA;
          end else begin
            tx_cnt_r <= tx_cnt_r - ONE_TICK;
          end
        end
        T_DATA: begin
          if (tx_cnt_r == ONE_TICK) begin
            tx_cnt_r <= BIT_TICKS;
            if (tx_idx_r == 3'd7) begin
              uart_tx_r  <= 1'b1;
              tx_state_r <= T_STOP;
            end else begin
              tx_idx_r   <= tx_idx_r + 3'd1;
              tx_shreg_r <= {1'b0, tx_shreg_r[7:1]};
              uart_tx_r  <= tx_shreg_r[1];
            end
          end else begin
            tx_cnt_r <= tx_cnt_r - ONE_TICK;
          end
        end
        T_STOP: begin
          if (tx_cnt_r == ONE_TICK) begin
            tx_busy_r  <= 1'b0;
            tx_state_r <= T_IDLE;
          end else begin
            tx_cnt_r <= tx_cnt_r - ONE_TICK;
          end
        end
        default: tx_state_r <= T_IDLE;
      endcase
    end
  end

  assign uart_tx    = uart_tx_r;
  assign tx_start   = tx_start_r;
  assign tx_busy    = tx_busy_r;
  assign rx_data    = rx_data_r;
  assign rx_data_en = rx_data_en_r;

endmodule
